// File: rtl/snitch_icache_pkg.sv
// Instruction-cache shared types: L0/L1 event pulse bundles and event counts.
package snitch_icache_pkg;

  localparam int unsigned NrL0Events = 5;
  localparam int unsigned NrL1Events = 6;

  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
  } icache_l0_events_t;

  typedef struct packed {
    logic l1_miss;
    logic l1_hit;
    logic l1_stall;
    logic l1_handler_stall;
    logic l1_tag_parity_error;
    logic l1_data_parity_error;
  } icache_l1_events_t;

endpackage

// File: rtl/snitch_icache_event_ctr.sv
// Single event counter with selectable saturate/wrap behaviour and a sticky overflow flag.
module snitch_icache_event_ctr #(
  parameter int unsigned CntWidth = 32,
  parameter bit          Saturate = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                inc_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                ovf_o
);

  logic [CntWidth-1:0] cnt_q;
  logic                ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear_i) begin
      // clear wins over a coincident event
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (inc_i) begin
      if (cnt_q == '1) begin
        ovf_q <= 1'b1;
        cnt_q <= Saturate ? cnt_q : '0;
      end else begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/snitch_icache_event_cnt.sv
// Performance counter bank for L0/L1 icache events with shadow snapshot, overflow irq
// and a one-cycle-latency read port.
module snitch_icache_event_cnt
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NrFetchPorts = 1,
  parameter int unsigned CntWidth     = 32,
  parameter bit          Saturate     = 1'b1,
  localparam int unsigned NrCnt       = NrL0Events * NrFetchPorts + NrL1Events,
  localparam int unsigned IdxWidth    = (NrCnt > 1) ? $clog2(NrCnt) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  icache_l0_events_t [NrFetchPorts-1:0] l0_events_i,
  input  icache_l1_events_t                    l1_events_i,
  input  logic                                 enable_i,
  input  logic                                 clear_i,
  input  logic                                 snapshot_i,
  input  logic                                 rd_valid_i,
  input  logic [IdxWidth-1:0]                  rd_idx_i,
  input  logic                                 rd_shadow_i,
  output logic                                 rd_ready_o,
  output logic                                 rd_rvalid_o,
  output logic [CntWidth-1:0]                  rd_data_o,
  output logic                                 rd_err_o,
  output logic [NrCnt-1:0]                     ovf_o,
  output logic                                 irq_o
);

  localparam int unsigned L1Base = NrL0Events * NrFetchPorts;

  logic [NrCnt-1:0]               evt;
  logic [NrCnt-1:0][CntWidth-1:0] live;
  logic [NrCnt-1:0][CntWidth-1:0] shadow_q;
  logic [CntWidth-1:0]            rd_sel;
  logic                           rd_hit;
  logic                           irq_q, rvalid_q, err_q;
  logic [CntWidth-1:0]            data_q;

  for (genvar p = 0; p < NrFetchPorts; p++) begin : g_l0
    assign evt[p*NrL0Events + 0] = l0_events_i[p].l0_miss;
    assign evt[p*NrL0Events + 1] = l0_events_i[p].l0_hit;
    assign evt[p*NrL0Events + 2] = l0_events_i[p].l0_prefetch;
    assign evt[p*NrL0Events + 3] = l0_events_i[p].l0_double_hit;
    assign evt[p*NrL0Events + 4] = l0_events_i[p].l0_stall;
  end

  assign evt[L1Base + 0] = l1_events_i.l1_miss;
  assign evt[L1Base + 1] = l1_events_i.l1_hit;
  assign evt[L1Base + 2] = l1_events_i.l1_stall;
  assign evt[L1Base + 3] = l1_events_i.l1_handler_stall;
  assign evt[L1Base + 4] = l1_events_i.l1_tag_parity_error;
  assign evt[L1Base + 5] = l1_events_i.l1_data_parity_error;

  for (genvar i = 0; i < NrCnt; i++) begin : g_ctr
    snitch_icache_event_ctr #(
      .CntWidth (CntWidth),
      .Saturate (Saturate)
    ) i_ctr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .inc_i   (enable_i & evt[i]),
      .cnt_o   (live[i]),
      .ovf_o   (ovf_o[i])
    );
  end

  // Snapshot samples the pre-edge live values, so a coincident clear/increment is excluded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         shadow_q <= '0;
    else if (snapshot_i) shadow_q <= live;
  end

  // Compare-based mux keeps out-of-range indices from ever addressing the arrays.
  always_comb begin
    rd_sel = '0;
    rd_hit = 1'b0;
    for (int unsigned i = 0; i < NrCnt; i++) begin
      if (rd_idx_i == IdxWidth'(i)) begin
        rd_hit = 1'b1;
        rd_sel = rd_shadow_i ? shadow_q[i] : live[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_valid_i;
      data_q   <= (rd_valid_i && rd_hit) ? rd_sel : '0;
      err_q    <= rd_valid_i & ~rd_hit;
      irq_q    <= |ovf_o;
    end
  end

  assign rd_ready_o  = 1'b1;
  assign rd_rvalid_o = rvalid_q;
  assign rd_data_o   = data_q;
  assign rd_err_o    = err_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_snitch_icache_event_cnt.sv
// Randomized + directed bench: two 8-bit counter banks (2-port saturating, 1-port wrapping)
// checked against a per-index integer model of the counter rules.
module tb_snitch_icache_event_cnt;
  import snitch_icache_pkg::*;

  localparam int NCA = 16;
  localparam int NCB = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit l0ev [2][5];
  bit l1ev [6];
  icache_l0_events_t [1:0] l0_a;
  icache_l0_events_t [0:0] l0_b;
  icache_l1_events_t       l1;
  logic       enable, clear, snapshot, rd_valid, rd_shadow;
  logic [3:0] rd_idx;

  logic           rdy_a, rv_a, err_a, irq_a;
  logic [7:0]     data_a;
  logic [NCA-1:0] ovf_a;
  logic           rdy_b, rv_b, err_b, irq_b;
  logic [7:0]     data_b;
  logic [NCB-1:0] ovf_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      l0_a[p].l0_miss       = l0ev[p][0];
      l0_a[p].l0_hit        = l0ev[p][1];
      l0_a[p].l0_prefetch   = l0ev[p][2];
      l0_a[p].l0_double_hit = l0ev[p][3];
      l0_a[p].l0_stall      = l0ev[p][4];
    end
    l1.l1_miss              = l1ev[0];
    l1.l1_hit               = l1ev[1];
    l1.l1_stall             = l1ev[2];
    l1.l1_handler_stall     = l1ev[3];
    l1.l1_tag_parity_error  = l1ev[4];
    l1.l1_data_parity_error = l1ev[5];
  end
  assign l0_b[0] = l0_a[0];

  snitch_icache_event_cnt #(.NrFetchPorts(2), .CntWidth(8), .Saturate(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .l0_events_i(l0_a), .l1_events_i(l1),
    .enable_i(enable), .clear_i(clear), .snapshot_i(snapshot),
    .rd_valid_i(rd_valid), .rd_idx_i(rd_idx), .rd_shadow_i(rd_shadow),
    .rd_ready_o(rdy_a), .rd_rvalid_o(rv_a), .rd_data_o(data_a), .rd_err_o(err_a),
    .ovf_o(ovf_a), .irq_o(irq_a));

  snitch_icache_event_cnt #(.NrFetchPorts(1), .CntWidth(8), .Saturate(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .l0_events_i(l0_b), .l1_events_i(l1),
    .enable_i(enable), .clear_i(clear), .snapshot_i(snapshot),
    .rd_valid_i(rd_valid), .rd_idx_i(rd_idx), .rd_shadow_i(rd_shadow),
    .rd_ready_o(rdy_b), .rd_rvalid_o(rv_b), .rd_data_o(data_b), .rd_err_o(err_b),
    .ovf_o(ovf_b), .irq_o(irq_b));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference model: [0] = bank A, [1] = bank B
  int unsigned lv [2][16];
  int unsigned sh [2][16];
  bit          ovm[2][16];
  int          ncnt[2] = '{NCA, NCB};
  bit          satm[2] = '{1'b1, 1'b0};
  logic [7:0]  obs_a, obs_b;
  logic        oerr_a, oerr_b;

  function automatic bit ev(int d, int i);
    int np;
    np = (d == 0) ? 2 : 1;
    if (i < 5 * np) return l0ev[i / 5][i % 5];
    return l1ev[i - 5 * np];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) begin
        lv[d][i] = 0; sh[d][i] = 0; ovm[d][i] = 1'b0;
      end
  endtask

  task automatic zero_in();
    for (int p = 0; p < 2; p++) for (int k = 0; k < 5; k++) l0ev[p][k] = 1'b0;
    for (int k = 0; k < 6; k++) l1ev[k] = 1'b0;
    clear = 1'b0; snapshot = 1'b0; rd_valid = 1'b0; rd_shadow = 1'b0; rd_idx = '0;
  endtask

  // One clock: predict from pre-edge model state, advance model, compare after the edge.
  task automatic cycle();
    logic [7:0]  pd[2];
    bit          pe[2];
    bit          pirq[2];
    bit          pv;
    logic [15:0] eo[2];
    pv = rd_valid;
    for (int d = 0; d < 2; d++) begin
      pirq[d] = 1'b0;
      for (int i = 0; i < ncnt[d]; i++) pirq[d] |= ovm[d][i];
      pd[d] = '0; pe[d] = 1'b0;
      if (pv) begin
        if (int'(rd_idx) >= ncnt[d]) pe[d] = 1'b1;
        else pd[d] = 8'(rd_shadow ? sh[d][rd_idx] : lv[d][rd_idx]);
      end
      if (snapshot) for (int i = 0; i < 16; i++) sh[d][i] = lv[d][i];
      eo[d] = '0;
      for (int i = 0; i < ncnt[d]; i++) begin
        if (clear) begin
          lv[d][i] = 0; ovm[d][i] = 1'b0;
        end else if (enable && ev(d, i)) begin
          if (lv[d][i] == 255) begin
            ovm[d][i] = 1'b1;
            lv[d][i]  = satm[d] ? 255 : 0;
          end else begin
            lv[d][i] = lv[d][i] + 1;
          end
        end
        eo[d][i] = ovm[d][i];
      end
    end
    @(posedge clk); #1;
    chk("rvalid_a", rv_a, pv);
    chk("rvalid_b", rv_b, pv);
    chk("data_a", data_a, pd[0]);
    chk("data_b", data_b, pd[1]);
    chk("err_a", err_a, pe[0]);
    chk("err_b", err_b, pe[1]);
    chk("irq_a", irq_a, pirq[0]);
    chk("irq_b", irq_b, pirq[1]);
    chk("ovf_a", ovf_a, eo[0]);
    chk("ovf_b", ovf_b, eo[1][NCB-1:0]);
    chk("ready_a", rdy_a, 1'b1);
    obs_a = data_a; obs_b = data_b; oerr_a = err_a; oerr_b = err_b;
  endtask

  task automatic rd(input logic [3:0] idx, input logic shadow);
    rd_valid = 1'b1; rd_idx = idx; rd_shadow = shadow;
    cycle();
    rd_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    zero_in();
    enable = 1'b1;
    model_reset();
    #2;
    chk("rst_rvalid", rv_a | rv_b, 1'b0);
    chk("rst_data", {data_a, data_b}, 16'h0);
    chk("rst_ovf", {ovf_a, ovf_b}, '0);
    chk("rst_irq", irq_a | irq_b, 1'b0);
    chk("rst_ready", rdy_a & rdy_b, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 260 l1_hit pulses: A saturates, B wraps to 4
    l1ev[1] = 1'b1;
    repeat (260) cycle();
    zero_in();
    rd(4'd11, 1'b0);
    chk("sat_l1hit", obs_a, 8'd255);
    chk("sat_l1hit_ovf", ovf_a[11], 1'b1);
    chk("sat_irq", irq_a, 1'b1);
    chk("idx11_err_b", oerr_b, 1'b1);
    chk("idx11_data_b", obs_b, 8'd0);
    rd(4'd6, 1'b0);
    chk("wrap_l1hit", obs_b, 8'd4);

    // 257 l0_miss on port 0: B wraps to 1, A stays 255
    pulse_clear();
    l0ev[0][0] = 1'b1;
    repeat (257) cycle();
    zero_in();
    rd(4'd0, 1'b0);
    chk("wrap_l0miss", obs_b, 8'd1);
    chk("wrap_l0miss_ovf", ovf_b[0], 1'b1);
    chk("sat_l0miss", obs_a, 8'd255);

    // port-1 l0_hit with enable dropped in the middle cycle
    pulse_clear();
    l0ev[1][1] = 1'b1;
    cycle();
    enable = 1'b0; cycle();
    enable = 1'b1; cycle();
    zero_in();
    rd(4'd6, 1'b0);
    chk("enable_gap", obs_a, 8'd2);

    // snapshot + clear + event in one cycle
    pulse_clear();
    l0ev[0][0] = 1'b1;
    repeat (10) cycle();
    snapshot = 1'b1; clear = 1'b1;
    cycle();
    zero_in();
    rd(4'd0, 1'b1);
    chk("snap_shadow_a", obs_a, 8'd10);
    chk("snap_shadow_b", obs_b, 8'd10);
    rd(4'd0, 1'b0);
    chk("snap_live_a", obs_a, 8'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) for (int k = 0; k < 5; k++) l0ev[p][k] = ($urandom % 3) == 0;
      for (int k = 0; k < 6; k++) l1ev[k] = ($urandom % 3) == 0;
      enable    = ($urandom % 5) != 0;
      clear     = ($urandom % 60) == 0;
      snapshot  = ($urandom % 20) == 0;
      rd_valid  = $urandom % 2;
      rd_idx    = 4'($urandom % 16);
      rd_shadow = $urandom % 2;
      cycle();
    end
    zero_in();
    enable = 1'b1;

    // counter 7 to 42, then reset with a read in flight
    pulse_clear();
    l0ev[1][2] = 1'b1; l1ev[2] = 1'b1;
    repeat (42) cycle();
    zero_in();
    rd(4'd7, 1'b0);
    chk("pre_rst_a", obs_a, 8'd42);
    chk("pre_rst_b", obs_b, 8'd42);
    rd_valid = 1'b1; rd_idx = 4'd7;
    @(posedge clk);
    #2 rst_n = 1'b0;
    rd_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_cancel_rvalid", rv_a | rv_b, 1'b0);
    chk("rst_cancel_data", {data_a, data_b}, 16'h0);
    chk("rst_cancel_ovf", {ovf_a, ovf_b}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cycle();
    rd(4'd7, 1'b0);
    chk("post_rst_a", obs_a, 8'd0);
    chk("post_rst_b", obs_b, 8'd0);
    rd(4'd11, 1'b1);
    chk("post_rst_shadow_a", obs_a, 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
